// File: rtl/vip_axi4_types_pkg.sv
// Shared AXI4 encodings and the write-arbiter state type.
package vip_axi4_types_pkg;

    // AWBURST / ARBURST encodings
    localparam logic [1:0] AXI4_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI4_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI4_BURST_WRAP  = 2'b10;

    // AWSIZE / ARSIZE encodings (bytes per beat)
    localparam logic [2:0] AXI4_SIZE_1B   = 3'b000;
    localparam logic [2:0] AXI4_SIZE_2B   = 3'b001;
    localparam logic [2:0] AXI4_SIZE_4B   = 3'b010;
    localparam logic [2:0] AXI4_SIZE_8B   = 3'b011;
    localparam logic [2:0] AXI4_SIZE_16B  = 3'b100;
    localparam logic [2:0] AXI4_SIZE_32B  = 3'b101;
    localparam logic [2:0] AXI4_SIZE_64B  = 3'b110;
    localparam logic [2:0] AXI4_SIZE_128B = 3'b111;

    // BRESP / RRESP encodings
    localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI4_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI4_RESP_DECERR = 2'b11;

    // Write arbiter burst-ownership states
    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        AW_S   = 2'd1,
        W_S    = 2'd2
    } axi4_wr_arb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first asserted request at or above ptr_i, wrapping.
module rr_priority_select #(
    parameter  int unsigned N_P         = 4,
    localparam int unsigned IDX_WIDTH_C = $clog2(N_P)
) (
    input  logic [N_P-1:0]         req_i,
    input  logic [IDX_WIDTH_C-1:0] ptr_i,
    output logic [IDX_WIDTH_C-1:0] idx_o,
    output logic                   valid_o
);

    // Scan N_P candidates starting at the pointer; the first hit wins.
    always_comb begin
        int unsigned cand;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < N_P; i++) begin
            cand = 32'(ptr_i) + i;
            if (cand >= N_P) begin
                cand = cand - N_P;
            end
            if (!valid_o && req_i[IDX_WIDTH_C'(cand)]) begin
                idx_o   = IDX_WIDTH_C'(cand);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_wr_arbiter.sv
// Round-robin AXI4 write arbiter: one whole burst (AW + W through WLAST) per grant,
// B responses routed back to their owner by the grant index prefixed onto the ID.
module axi4_wr_arbiter
    import vip_axi4_types_pkg::*;
#(
    parameter  int unsigned NR_OF_REQUESTERS_P = 4,
    parameter  int unsigned ID_WIDTH_P         = 4,
    parameter  int unsigned ADDR_WIDTH_P       = 32,
    parameter  int unsigned DATA_WIDTH_P       = 64,
    parameter  int unsigned STRB_WIDTH_P       = DATA_WIDTH_P / 8,
    localparam int unsigned IDX_WIDTH_C        = $clog2(NR_OF_REQUESTERS_P)
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    // requester side
    input  logic [NR_OF_REQUESTERS_P-1:0]                     req_awvalid,
    output logic [NR_OF_REQUESTERS_P-1:0]                     req_awready,
    input  logic [NR_OF_REQUESTERS_P-1:0][ID_WIDTH_P-1:0]     req_awid,
    input  logic [NR_OF_REQUESTERS_P-1:0][ADDR_WIDTH_P-1:0]   req_awaddr,
    input  logic [NR_OF_REQUESTERS_P-1:0][7:0]                req_awlen,
    input  logic [NR_OF_REQUESTERS_P-1:0][2:0]                req_awsize,
    input  logic [NR_OF_REQUESTERS_P-1:0][1:0]                req_awburst,
    input  logic [NR_OF_REQUESTERS_P-1:0]                     req_wvalid,
    output logic [NR_OF_REQUESTERS_P-1:0]                     req_wready,
    input  logic [NR_OF_REQUESTERS_P-1:0][DATA_WIDTH_P-1:0]   req_wdata,
    input  logic [NR_OF_REQUESTERS_P-1:0][STRB_WIDTH_P-1:0]   req_wstrb,
    input  logic [NR_OF_REQUESTERS_P-1:0]                     req_wlast,
    output logic [NR_OF_REQUESTERS_P-1:0]                     req_bvalid,
    input  logic [NR_OF_REQUESTERS_P-1:0]                     req_bready,
    output logic [NR_OF_REQUESTERS_P-1:0][ID_WIDTH_P-1:0]     req_bid,
    output logic [NR_OF_REQUESTERS_P-1:0][1:0]                req_bresp,
    // shared master side
    output logic                                              mst_awvalid,
    input  logic                                              mst_awready,
    output logic [IDX_WIDTH_C+ID_WIDTH_P-1:0]                 mst_awid,
    output logic [ADDR_WIDTH_P-1:0]                           mst_awaddr,
    output logic [7:0]                                        mst_awlen,
    output logic [2:0]                                        mst_awsize,
    output logic [1:0]                                        mst_awburst,
    output logic                                              mst_wvalid,
    input  logic                                              mst_wready,
    output logic [DATA_WIDTH_P-1:0]                           mst_wdata,
    output logic [STRB_WIDTH_P-1:0]                           mst_wstrb,
    output logic                                              mst_wlast,
    input  logic                                              mst_bvalid,
    output logic                                              mst_bready,
    input  logic [IDX_WIDTH_C+ID_WIDTH_P-1:0]                 mst_bid,
    input  logic [1:0]                                        mst_bresp,
    output logic                                              burst_active
);

    axi4_wr_arb_state_t       state_q, state_d;
    logic [IDX_WIDTH_C-1:0]   grant_idx_q, grant_idx_d;
    logic [IDX_WIDTH_C-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_WIDTH_C-1:0]   pick_idx;
    logic                     pick_valid;
    logic [IDX_WIDTH_C-1:0]   b_sel;

    rr_priority_select #(
        .N_P (NR_OF_REQUESTERS_P)
    ) u_rr_select (
        .req_i   (req_awvalid),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE_S;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Next state and AW/W forwarding; unselected channels drive zeros.
    always_comb begin
        state_d      = state_q;
        grant_idx_d  = grant_idx_q;
        rr_ptr_d     = rr_ptr_q;
        req_awready  = '0;
        req_wready   = '0;
        mst_awvalid  = 1'b0;
        mst_awid     = '0;
        mst_awaddr   = '0;
        mst_awlen    = '0;
        mst_awsize   = '0;
        mst_awburst  = '0;
        mst_wvalid   = 1'b0;
        mst_wdata    = '0;
        mst_wstrb    = '0;
        mst_wlast    = 1'b0;
        burst_active = 1'b0;

        case (state_q)
            IDLE_S: begin
                if (pick_valid) begin
                    grant_idx_d = pick_idx;
                    rr_ptr_d    = (pick_idx == IDX_WIDTH_C'(NR_OF_REQUESTERS_P - 1))
                                  ? '0 : pick_idx + IDX_WIDTH_C'(1);
                    state_d     = AW_S;
                end
            end
            AW_S: begin
                burst_active             = 1'b1;
                mst_awvalid              = req_awvalid[grant_idx_q];
                mst_awid                 = {grant_idx_q, req_awid[grant_idx_q]};
                mst_awaddr               = req_awaddr[grant_idx_q];
                mst_awlen                = req_awlen[grant_idx_q];
                mst_awsize               = req_awsize[grant_idx_q];
                mst_awburst              = req_awburst[grant_idx_q];
                req_awready[grant_idx_q] = mst_awready;
                if (req_awvalid[grant_idx_q] && mst_awready) begin
                    state_d = W_S;
                end
            end
            W_S: begin
                burst_active            = 1'b1;
                mst_wvalid              = req_wvalid[grant_idx_q];
                mst_wdata               = req_wdata[grant_idx_q];
                mst_wstrb               = req_wstrb[grant_idx_q];
                mst_wlast               = req_wlast[grant_idx_q];
                req_wready[grant_idx_q] = mst_wready;
                if (req_wvalid[grant_idx_q] && mst_wready && req_wlast[grant_idx_q]) begin
                    state_d = IDLE_S;
                end
            end
            default: begin
                state_d = IDLE_S;
            end
        endcase
    end

    assign b_sel = mst_bid[IDX_WIDTH_C+ID_WIDTH_P-1 -: IDX_WIDTH_C];

    // B routing by ID prefix; a prefix beyond the requester count is accepted and dropped.
    always_comb begin
        req_bvalid = '0;
        req_bid    = '0;
        req_bresp  = '0;
        mst_bready = 1'b1;
        if ({1'b0, b_sel} < (IDX_WIDTH_C + 1)'(NR_OF_REQUESTERS_P)) begin
            req_bvalid[b_sel] = mst_bvalid;
            req_bid[b_sel]    = mst_bid[ID_WIDTH_P-1:0];
            req_bresp[b_sel]  = mst_bresp;
            mst_bready        = req_bready[b_sel];
        end
    end

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Directed bench for axi4_wr_arbiter (N=4 main instance, N=3 instance for B prefix range).
module tb_axi4_wr_arbiter;
    import vip_axi4_types_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned N3 = 3;
    localparam int unsigned IW = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned XW = 2;

    logic clk;
    logic rst_n;

    logic [N-1:0]           req_awvalid, req_awready;
    logic [N-1:0][IW-1:0]   req_awid;
    logic [N-1:0][AW-1:0]   req_awaddr;
    logic [N-1:0][7:0]      req_awlen;
    logic [N-1:0][2:0]      req_awsize;
    logic [N-1:0][1:0]      req_awburst;
    logic [N-1:0]           req_wvalid, req_wready;
    logic [N-1:0][DW-1:0]   req_wdata;
    logic [N-1:0][SW-1:0]   req_wstrb;
    logic [N-1:0]           req_wlast;
    logic [N-1:0]           req_bvalid, req_bready;
    logic [N-1:0][IW-1:0]   req_bid;
    logic [N-1:0][1:0]      req_bresp;
    logic                   mst_awvalid, mst_awready;
    logic [XW+IW-1:0]       mst_awid;
    logic [AW-1:0]          mst_awaddr;
    logic [7:0]             mst_awlen;
    logic [2:0]             mst_awsize;
    logic [1:0]             mst_awburst;
    logic                   mst_wvalid, mst_wready;
    logic [DW-1:0]          mst_wdata;
    logic [SW-1:0]          mst_wstrb;
    logic                   mst_wlast;
    logic                   mst_bvalid, mst_bready;
    logic [XW+IW-1:0]       mst_bid;
    logic [1:0]             mst_bresp;
    logic                   burst_active;

    // N=3 instance signals (only the B channel is exercised)
    logic [N3-1:0]          b3_req_awready, b3_req_wready, b3_req_bvalid, b3_req_bready;
    logic [N3-1:0][IW-1:0]  b3_req_bid;
    logic [N3-1:0][1:0]     b3_req_bresp;
    logic                   b3_mst_awvalid, b3_mst_wvalid, b3_mst_wlast, b3_mst_bvalid, b3_mst_bready;
    logic [XW+IW-1:0]       b3_mst_awid, b3_mst_bid;
    logic [AW-1:0]          b3_mst_awaddr;
    logic [7:0]             b3_mst_awlen;
    logic [2:0]             b3_mst_awsize;
    logic [1:0]             b3_mst_awburst;
    logic [DW-1:0]          b3_mst_wdata;
    logic [SW-1:0]          b3_mst_wstrb;
    logic                   b3_burst_active;

    int checks = 0;
    int errors = 0;

    axi4_wr_arbiter #(
        .NR_OF_REQUESTERS_P (N), .ID_WIDTH_P (IW), .ADDR_WIDTH_P (AW), .DATA_WIDTH_P (DW)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .req_awvalid (req_awvalid), .req_awready (req_awready), .req_awid (req_awid),
        .req_awaddr (req_awaddr), .req_awlen (req_awlen), .req_awsize (req_awsize),
        .req_awburst (req_awburst), .req_wvalid (req_wvalid), .req_wready (req_wready),
        .req_wdata (req_wdata), .req_wstrb (req_wstrb), .req_wlast (req_wlast),
        .req_bvalid (req_bvalid), .req_bready (req_bready), .req_bid (req_bid),
        .req_bresp (req_bresp),
        .mst_awvalid (mst_awvalid), .mst_awready (mst_awready), .mst_awid (mst_awid),
        .mst_awaddr (mst_awaddr), .mst_awlen (mst_awlen), .mst_awsize (mst_awsize),
        .mst_awburst (mst_awburst), .mst_wvalid (mst_wvalid), .mst_wready (mst_wready),
        .mst_wdata (mst_wdata), .mst_wstrb (mst_wstrb), .mst_wlast (mst_wlast),
        .mst_bvalid (mst_bvalid), .mst_bready (mst_bready), .mst_bid (mst_bid),
        .mst_bresp (mst_bresp), .burst_active (burst_active)
    );

    axi4_wr_arbiter #(
        .NR_OF_REQUESTERS_P (N3), .ID_WIDTH_P (IW), .ADDR_WIDTH_P (AW), .DATA_WIDTH_P (DW)
    ) dut3 (
        .clk (clk), .rst_n (rst_n),
        .req_awvalid ('0), .req_awready (b3_req_awready), .req_awid ('0),
        .req_awaddr ('0), .req_awlen ('0), .req_awsize ('0),
        .req_awburst ('0), .req_wvalid ('0), .req_wready (b3_req_wready),
        .req_wdata ('0), .req_wstrb ('0), .req_wlast ('0),
        .req_bvalid (b3_req_bvalid), .req_bready (b3_req_bready), .req_bid (b3_req_bid),
        .req_bresp (b3_req_bresp),
        .mst_awvalid (b3_mst_awvalid), .mst_awready (1'b1), .mst_awid (b3_mst_awid),
        .mst_awaddr (b3_mst_awaddr), .mst_awlen (b3_mst_awlen), .mst_awsize (b3_mst_awsize),
        .mst_awburst (b3_mst_awburst), .mst_wvalid (b3_mst_wvalid), .mst_wready (1'b1),
        .mst_wdata (b3_mst_wdata), .mst_wstrb (b3_mst_wstrb), .mst_wlast (b3_mst_wlast),
        .mst_bvalid (b3_mst_bvalid), .mst_bready (b3_mst_bready), .mst_bid (b3_mst_bid),
        .mst_bresp (2'b00), .burst_active (b3_burst_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        req_awvalid = '0; req_awid = '0; req_awaddr = '0; req_awlen = '0;
        req_awsize = '0; req_awburst = '0; req_wvalid = '0; req_wdata = '0;
        req_wstrb = '0; req_wlast = '0; req_bready = '0;
        mst_awready = 1'b1; mst_wready = 1'b1; mst_bvalid = 1'b0; mst_bid = '0;
        mst_bresp = '0; b3_req_bready = '0; b3_mst_bvalid = 1'b0; b3_mst_bid = '0;
    endtask

    // Reset, release on a falling edge, return just after the next rising edge in IDLE_S.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        req_awvalid = '1; req_wvalid = '1; req_wlast = '1;
        req_awaddr[0] = 32'h1234_5678; req_wdata[0] = 64'hFFFF;
        @(posedge clk);
        @(negedge clk);
        checks++; if (burst_active !== 1'b0) begin errors++; $display("FAIL reset_burst_active: got %0b want 0", burst_active); end
        checks++; if ({mst_awvalid, mst_wvalid} !== 2'b00) begin errors++; $display("FAIL reset_mst_valids: got %b want 00", {mst_awvalid, mst_wvalid}); end
        checks++; if ({req_awready, req_wready} !== 8'h00) begin errors++; $display("FAIL reset_req_readies: got %h want 00", {req_awready, req_wready}); end
        checks++; if (mst_awaddr !== 32'h0 || mst_wdata !== 64'h0 || mst_awid !== 6'h0) begin errors++; $display("FAIL reset_fwd_zero: addr %0h data %0h id %0h want 0", mst_awaddr, mst_wdata, mst_awid); end
        checks++; if (dut.state_q !== IDLE_S) begin errors++; $display("FAIL reset_state: got %0d want IDLE_S", dut.state_q); end
    endtask

    task automatic test_single_burst();
        do_reset();
        req_awvalid[2] = 1'b1; req_awid[2] = 4'h5; req_awaddr[2] = 32'h0000_1000;
        req_awlen[2] = 8'd3; req_awsize[2] = AXI4_SIZE_8B; req_awburst[2] = AXI4_BURST_INCR;
        @(negedge clk);
        checks++; if (mst_awvalid !== 1'b0) begin errors++; $display("FAIL single_idle_cycle: mst_awvalid %0b want 0", mst_awvalid); end
        @(negedge clk);
        checks++; if (mst_awvalid !== 1'b1 || mst_awid !== 6'h25) begin errors++; $display("FAIL single_aw: valid %0b id %0h want 1 25", mst_awvalid, mst_awid); end
        checks++; if (mst_awaddr !== 32'h1000 || mst_awlen !== 8'd3 || mst_awburst !== AXI4_BURST_INCR) begin errors++; $display("FAIL single_aw_fields: addr %0h len %0d burst %0d", mst_awaddr, mst_awlen, mst_awburst); end
        checks++; if (req_awready !== 4'b0100) begin errors++; $display("FAIL single_awready: got %b want 0100", req_awready); end
        @(posedge clk); #1;
        req_awvalid[2] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            req_wvalid[2] = 1'b1; req_wdata[2] = 64'hA0 + 64'(b); req_wstrb[2] = 8'hFF;
            req_wlast[2] = (b == 3);
            @(negedge clk);
            checks++; if (mst_wvalid !== 1'b1 || mst_wdata !== 64'hA0 + 64'(b) || mst_wlast !== (b == 3)) begin errors++; $display("FAIL single_wbeat%0d: valid %0b data %0h last %0b", b, mst_wvalid, mst_wdata, mst_wlast); end
            checks++; if (req_wready !== 4'b0100) begin errors++; $display("FAIL single_wready%0d: got %b want 0100", b, req_wready); end
            @(posedge clk); #1;
        end
        req_wvalid[2] = 1'b0; req_wlast[2] = 1'b0;
        @(negedge clk);
        checks++; if (burst_active !== 1'b0) begin errors++; $display("FAIL single_end_idle: burst_active %0b want 0", burst_active); end
        mst_bvalid = 1'b1; mst_bid = 6'h25; mst_bresp = AXI4_RESP_SLVERR; req_bready = 4'b0100;
        #1;
        checks++; if (req_bvalid !== 4'b0100 || req_bid[2] !== 4'h5 || req_bresp[2] !== AXI4_RESP_SLVERR) begin errors++; $display("FAIL single_b_route: bvalid %b bid %0h bresp %0d", req_bvalid, req_bid[2], req_bresp[2]); end
        checks++; if (req_bid[0] !== 4'h0 || mst_bready !== 1'b1) begin errors++; $display("FAIL single_b_other: bid0 %0h bready %0b want 0 1", req_bid[0], mst_bready); end
        req_bready = 4'b1011;
        #1;
        checks++; if (mst_bready !== 1'b0) begin errors++; $display("FAIL single_b_ready_sel: got %0b want 0", mst_bready); end
        mst_bvalid = 1'b0; req_bready = '0;
    endtask

    task automatic test_round_robin();
        logic [XW+IW-1:0] exp_id;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_awid[i] = 4'(i); req_awlen[i] = 8'd0; req_wdata[i] = 64'(i);
        end
        req_awvalid = '1; req_wvalid = '1; req_wlast = '1;
        for (int k = 0; k < 5; k++) begin
            exp_id = {2'(k % 4), 4'(k % 4)};
            @(posedge clk);
            @(negedge clk);
            checks++; if (mst_awvalid !== 1'b1 || mst_awid !== exp_id || mst_wvalid !== 1'b0) begin errors++; $display("FAIL rr_grant%0d: awvalid %0b awid %0h wvalid %0b want 1 %0h 0", k, mst_awvalid, mst_awid, mst_wvalid, exp_id); end
            @(posedge clk);
            @(negedge clk);
            checks++; if (mst_wvalid !== 1'b1 || mst_wlast !== 1'b1 || mst_wdata !== 64'(k % 4)) begin errors++; $display("FAIL rr_w%0d: wvalid %0b wlast %0b data %0h", k, mst_wvalid, mst_wlast, mst_wdata); end
            @(posedge clk);
            @(negedge clk);
            checks++; if (burst_active !== 1'b0 || mst_awvalid !== 1'b0) begin errors++; $display("FAIL rr_bubble%0d: burst_active %0b awvalid %0b want 0 0", k, burst_active, mst_awvalid); end
        end
        req_awvalid = '0; req_wvalid = '0; req_wlast = '0;
    endtask

    task automatic test_len0();
        do_reset();
        req_awvalid[1] = 1'b1; req_awid[1] = 4'h9; req_awlen[1] = 8'd0;
        req_wvalid[1] = 1'b1; req_wlast[1] = 1'b1; req_wdata[1] = 64'hBEEF;
        @(posedge clk);
        @(negedge clk);
        checks++; if (mst_awvalid !== 1'b1 || mst_awlen !== 8'd0 || mst_wvalid !== 1'b0 || req_wready !== 4'b0000) begin errors++; $display("FAIL len0_aw: awvalid %0b len %0d wvalid %0b wready %b", mst_awvalid, mst_awlen, mst_wvalid, req_wready); end
        @(posedge clk); #1;
        req_awvalid[1] = 1'b0;
        @(negedge clk);
        checks++; if (mst_wvalid !== 1'b1 || mst_wlast !== 1'b1 || req_wready !== 4'b0010 || mst_wdata !== 64'hBEEF) begin errors++; $display("FAIL len0_w: wvalid %0b wlast %0b wready %b data %0h", mst_wvalid, mst_wlast, req_wready, mst_wdata); end
        @(posedge clk); #1;
        req_wvalid[1] = 1'b0; req_wlast[1] = 1'b0;
        @(negedge clk);
        checks++; if (burst_active !== 1'b0 || dut.state_q !== IDLE_S) begin errors++; $display("FAIL len0_idle: burst_active %0b state %0d want 0 IDLE_S", burst_active, dut.state_q); end
    endtask

    task automatic test_aw_stall();
        do_reset();
        mst_awready = 1'b0;
        req_awvalid[3] = 1'b1; req_awid[3] = 4'hC; req_awaddr[3] = 32'hDEAD_BEE0; req_awlen[3] = 8'd1;
        req_wvalid[3] = 1'b1; req_wdata[3] = 64'h5555; req_wlast[3] = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (mst_awvalid !== 1'b1 || mst_awaddr !== 32'hDEAD_BEE0 || mst_awid !== 6'h3C || mst_awlen !== 8'd1) begin errors++; $display("FAIL stall_aw%0d: valid %0b addr %0h id %0h len %0d", c, mst_awvalid, mst_awaddr, mst_awid, mst_awlen); end
            checks++; if (mst_wvalid !== 1'b0 || req_wready !== 4'b0000 || req_awready !== 4'b0000 || mst_wdata !== 64'h0) begin errors++; $display("FAIL stall_w%0d: wvalid %0b wready %b awready %b wdata %0h", c, mst_wvalid, req_wready, req_awready, mst_wdata); end
            @(posedge clk);
        end
        @(negedge clk);
        mst_awready = 1'b1;
        #1;
        checks++; if (req_awready !== 4'b1000) begin errors++; $display("FAIL stall_release: awready %b want 1000", req_awready); end
        @(posedge clk); #1;
        req_awvalid[3] = 1'b0;
        @(negedge clk);
        checks++; if (mst_wvalid !== 1'b1 || req_wready !== 4'b1000 || mst_wdata !== 64'h5555) begin errors++; $display("FAIL stall_w_after: wvalid %0b wready %b data %0h", mst_wvalid, req_wready, mst_wdata); end
    endtask

    task automatic test_bid_out_of_range();
        b3_mst_bvalid = 1'b1; b3_mst_bid = {2'd3, 4'hA}; b3_req_bready = 3'b000;
        #1;
        checks++; if (b3_mst_bready !== 1'b1 || b3_req_bvalid !== 3'b000) begin errors++; $display("FAIL n3_prefix3: bready %0b bvalid %b want 1 000", b3_mst_bready, b3_req_bvalid); end
        b3_mst_bid = {2'd2, 4'hA};
        #1;
        checks++; if (b3_mst_bready !== 1'b0 || b3_req_bvalid !== 3'b100 || b3_req_bid[2] !== 4'hA) begin errors++; $display("FAIL n3_prefix2: bready %0b bvalid %b bid %0h want 0 100 a", b3_mst_bready, b3_req_bvalid, b3_req_bid[2]); end
        b3_mst_bvalid = 1'b0; b3_mst_bid = '0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_awvalid[0] = 1'b1; req_awid[0] = 4'hA; req_awlen[0] = 8'd7;
        @(posedge clk);
        @(posedge clk); #1;
        req_awvalid[0] = 1'b0; req_wvalid[0] = 1'b1; req_wdata[0] = 64'h100;
        @(posedge clk); #1;
        req_wdata[0] = 64'h101;
        @(negedge clk);
        checks++; if (mst_wvalid !== 1'b1 || mst_wdata !== 64'h101) begin errors++; $display("FAIL midrst_beat2: wvalid %0b data %0h want 1 101", mst_wvalid, mst_wdata); end
        rst_n = 1'b0;
        #1;
        checks++; if ({mst_awvalid, mst_wvalid, burst_active} !== 3'b000 || {req_awready, req_wready} !== 8'h00) begin errors++; $display("FAIL midrst_outputs: valids %b readies %h want 000 00", {mst_awvalid, mst_wvalid, burst_active}, {req_awready, req_wready}); end
        checks++; if (dut.state_q !== IDLE_S || mst_wdata !== 64'h0) begin errors++; $display("FAIL midrst_state: state %0d wdata %0h want IDLE_S 0", dut.state_q, mst_wdata); end
        req_wvalid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_awvalid = 4'b0011; req_awid[0] = 4'hA; req_awid[1] = 4'hB;
        @(posedge clk);
        @(negedge clk);
        checks++; if (mst_awvalid !== 1'b1 || mst_awid !== 6'h0A) begin errors++; $display("FAIL midrst_restart: awvalid %0b awid %0h want 1 0a", mst_awvalid, mst_awid); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_len0();
        test_aw_stall();
        test_bid_out_of_range();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so a stuck DUT cannot hang the run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
